// File: rtl/control_pkg.sv
// Shared opcode map, FSM states, control-field codes and the decoded control word.
// Imported by the decoder and the sequencing FSM.
package control_pkg;

  localparam int JB_BITS = 3;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_ANDI = 4'b0001;
  localparam logic [3:0] OP_ORI  = 4'b0010;
  localparam logic [3:0] OP_BGT  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_LBU  = 4'b1010;
  localparam logic [3:0] OP_SB   = 4'b1011;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;
  localparam logic [3:0] OP_ALU  = 4'b1111;

  localparam logic [1:0] ALU_ADDSUB = 2'b00;
  localparam logic [1:0] ALU_AND    = 2'b01;
  localparam logic [1:0] ALU_ADDR   = 2'b10;
  localparam logic [1:0] ALU_OR     = 2'b11;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_ALU  = 2'b01;
  localparam logic [1:0] RW_MEM  = 2'b10;
  localparam logic [1:0] RW_MD   = 2'b11;

  localparam logic [JB_BITS-1:0] JB_NONE = 3'b000;
  localparam logic [JB_BITS-1:0] JB_BLT  = 3'b001;
  localparam logic [JB_BITS-1:0] JB_BGT  = 3'b010;
  localparam logic [JB_BITS-1:0] JB_BEQ  = 3'b011;
  localparam logic [JB_BITS-1:0] JB_JUMP = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_MD_WAIT, S_MEM_WAIT, S_HALTED
  } state_t;

  // How the FSM sequences an accepted opcode after its ISSUE cycle.
  typedef enum logic [2:0] {
    K_SINGLE, K_MD, K_LOAD, K_STORE, K_HALT
  } op_kind_t;

  typedef struct packed {
    logic               aluBType;
    logic               aluSrc;
    logic               signExtend;
    logic               memRead;
    logic               memToReg;
    logic               memWrite;
    logic [1:0]         aluControlOp;
    logic [1:0]         regWrite;
    logic [JB_BITS-1:0] jumpBranch;
  } ctrl_word_t;

  function automatic ctrl_word_t mem_word(input logic is_load, input logic is_byte_load);
    ctrl_word_t w;
    w              = '0;
    w.aluBType     = 1'b1;
    w.aluSrc       = 1'b1;
    w.aluControlOp = ALU_ADDR;
    w.memRead      = is_load;
    w.memToReg     = is_load;
    w.signExtend   = is_load & is_byte_load;
    w.memWrite     = ~is_load;
    w.regWrite     = is_load ? RW_MEM : RW_NONE;
    return w;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational {opcode, multiDiv} -> control word, sequencing class and illegal flag.
// Unknown opcodes yield an all-zero word so nothing downstream acts on them.
module control_decode
  import control_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic        i_multi_div,
  output ctrl_word_t  o_word,
  output op_kind_t    o_kind,
  output logic        o_illegal
);

  always_comb begin
    o_word    = '0;
    o_kind    = K_SINGLE;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_ALU: begin
        o_word.aluControlOp = ALU_ADDSUB;
        if (i_multi_div) begin
          o_word.regWrite = RW_MD;
          o_kind          = K_MD;
        end else begin
          o_word.regWrite = RW_ALU;
        end
      end
      OP_ANDI: begin
        o_word.aluSrc       = 1'b1;
        o_word.aluControlOp = ALU_AND;
        o_word.regWrite     = RW_ALU;
      end
      OP_ORI: begin
        o_word.aluSrc       = 1'b1;
        o_word.aluControlOp = ALU_OR;
        o_word.regWrite     = RW_ALU;
      end
      OP_LW: begin
        o_word = mem_word(1'b1, 1'b0);
        o_kind = K_LOAD;
      end
      OP_LBU: begin
        o_word = mem_word(1'b1, 1'b1);
        o_kind = K_LOAD;
      end
      OP_SW, OP_SB: begin
        o_word = mem_word(1'b0, 1'b0);
        o_kind = K_STORE;
      end
      OP_BLT:  o_word.jumpBranch = JB_BLT;
      OP_BGT:  o_word.jumpBranch = JB_BGT;
      OP_BEQ:  o_word.jumpBranch = JB_BEQ;
      OP_JMP:  o_word.jumpBranch = JB_JUMP;
      OP_HALT: o_kind = K_HALT;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing control unit: accepts one opcode per handshake, issues the decoded word for one cycle,
// then holds it through mult/div and memory waits; HALT is sticky until reset.
module multicycle_control
  import control_pkg::*;
#(
  parameter int MD_CYCLES = 4,
  parameter int JB_W      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [3:0]      opcode,
  input  logic            multiDiv,
  input  logic            mem_ack,
  output logic            instr_ready,
  output logic            ctrl_valid,
  output logic            aluBType,
  output logic            aluSrc,
  output logic            signExtend,
  output logic            memRead,
  output logic            memToReg,
  output logic            memWrite,
  output logic [1:0]      aluControlOp,
  output logic [1:0]      regWrite,
  output logic [JB_W-1:0] jumpBranch,
  output logic            busy,
  output logic            halted,
  output logic            illegal_op
);

  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  state_t          r_state;
  ctrl_word_t      r_word;
  op_kind_t        r_kind;
  logic            r_illegal;
  logic [CNT_W-1:0] r_cnt;

  ctrl_word_t w_dec_word;
  op_kind_t   w_dec_kind;
  logic       w_dec_illegal;
  logic       w_active;
  ctrl_word_t w_out;
  logic [1:0] w_regwrite;

  control_decode u_decode (
    .i_opcode    (opcode),
    .i_multi_div (multiDiv),
    .o_word      (w_dec_word),
    .o_kind      (w_dec_kind),
    .o_illegal   (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_word    <= '0;
      r_kind    <= K_SINGLE;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_word    <= w_dec_word;
            r_kind    <= w_dec_kind;
            r_illegal <= w_dec_illegal;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          case (r_kind)
            K_MD: begin
              r_cnt   <= CNT_W'(MD_CYCLES - 1);
              r_state <= (MD_CYCLES > 1) ? S_MD_WAIT : S_IDLE;
            end
            K_LOAD, K_STORE: r_state <= mem_ack ? S_IDLE : S_MEM_WAIT;
            K_HALT:          r_state <= S_HALTED;
            default:         r_state <= S_IDLE;
          endcase
        end
        S_MD_WAIT: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_MEM_WAIT: begin
          if (mem_ack) r_state <= S_IDLE;
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign w_active = (r_state == S_ISSUE) || (r_state == S_MD_WAIT) || (r_state == S_MEM_WAIT);
  assign w_out    = w_active ? r_word : '0;

  // Write-back strobes fire only on the completing cycle of a multi-cycle op.
  always_comb begin
    w_regwrite = RW_NONE;
    if (w_active) begin
      case (r_kind)
        K_MD: begin
          if (((r_state == S_ISSUE) && (MD_CYCLES == 1)) ||
              ((r_state == S_MD_WAIT) && (r_cnt == '0)))
            w_regwrite = RW_MD;
        end
        K_LOAD:  if (mem_ack) w_regwrite = RW_MEM;
        default: if (r_state == S_ISSUE) w_regwrite = r_word.regWrite;
      endcase
    end
  end

  assign instr_ready  = (r_state == S_IDLE);
  assign ctrl_valid   = (r_state == S_ISSUE);
  assign busy         = (r_state != S_IDLE);
  assign halted       = (r_state == S_HALTED);
  assign illegal_op   = (r_state == S_ISSUE) && r_illegal;
  assign aluBType     = w_out.aluBType;
  assign aluSrc       = w_out.aluSrc;
  assign signExtend   = w_out.signExtend;
  assign memRead      = w_out.memRead;
  assign memToReg     = w_out.memToReg;
  assign memWrite     = w_out.memWrite;
  assign aluControlOp = w_out.aluControlOp;
  assign regWrite     = w_regwrite;
  assign jumpBranch   = JB_W'(w_out.jumpBranch);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: decode table through a scoreboard, then hand-built
// mult/div, memory-wait, HALT and reset-abort sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [3:0] opcode = 4'b0;
  logic       multiDiv = 1'b0;
  logic       mem_ack = 1'b0;
  logic       instr_ready, ctrl_valid, aluBType, aluSrc, signExtend;
  logic       memRead, memToReg, memWrite, busy, halted, illegal_op;
  logic [1:0] aluControlOp, regWrite;
  logic [2:0] jumpBranch;

  always #5 clk = ~clk;

  multicycle_control #(.MD_CYCLES(4), .JB_W(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .multiDiv(multiDiv), .mem_ack(mem_ack), .instr_ready(instr_ready),
    .ctrl_valid(ctrl_valid), .aluBType(aluBType), .aluSrc(aluSrc),
    .signExtend(signExtend), .memRead(memRead), .memToReg(memToReg),
    .memWrite(memWrite), .aluControlOp(aluControlOp), .regWrite(regWrite),
    .jumpBranch(jumpBranch), .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [3:0]  op;
    logic        md;
    logic [12:0] ctl;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [12:0] ctl;
    logic        ill;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];
  vec_t tbl[15];

  // {aluBType, aluSrc, signExtend, memRead, memToReg, memWrite, aluControlOp, regWrite, jumpBranch}
  function automatic logic [12:0] mk(bit bt, bit src, bit se, bit mr, bit mtr, bit mw,
                                     bit [1:0] op, bit [1:0] rw, bit [2:0] jb);
    return {bt, src, se, mr, mtr, mw, op, rw, jb};
  endfunction

  function automatic logic [12:0] ctl_now();
    return {aluBType, aluSrc, signExtend, memRead, memToReg, memWrite,
            aluControlOp, regWrite, jumpBranch};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int   w;
    exp_t e;
    logic saw_md_wb;

    tbl[0]  = '{4'b0001, 1'b0, mk(0,1,0,0,0,0,2'b01,2'b01,3'b000), 1'b0};
    tbl[1]  = '{4'b0010, 1'b0, mk(0,1,0,0,0,0,2'b11,2'b01,3'b000), 1'b0};
    tbl[2]  = '{4'b1111, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,3'b000), 1'b0};
    tbl[3]  = '{4'b1100, 1'b0, mk(1,1,0,1,1,0,2'b10,2'b10,3'b000), 1'b0};
    tbl[4]  = '{4'b1010, 1'b0, mk(1,1,1,1,1,0,2'b10,2'b10,3'b000), 1'b0};
    tbl[5]  = '{4'b1101, 1'b0, mk(1,1,0,0,0,1,2'b10,2'b00,3'b000), 1'b0};
    tbl[6]  = '{4'b1011, 1'b0, mk(1,1,0,0,0,1,2'b10,2'b00,3'b000), 1'b0};
    tbl[7]  = '{4'b0101, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,3'b001), 1'b0};
    tbl[8]  = '{4'b0100, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,3'b010), 1'b0};
    tbl[9]  = '{4'b0110, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,3'b011), 1'b0};
    tbl[10] = '{4'b0111, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,3'b100), 1'b0};
    tbl[11] = '{4'b1000, 1'b0, 13'h0, 1'b1};
    tbl[12] = '{4'b0011, 1'b1, 13'h0, 1'b1};
    tbl[13] = '{4'b1110, 1'b0, 13'h0, 1'b1};
    tbl[14] = '{4'b0001, 1'b1, mk(0,1,0,0,0,0,2'b01,2'b01,3'b000), 1'b0};

    // Reset state
    do_reset();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_ctl", ctl_now(), 0);

    // Decode table, zero-wait memory completion, 2-cycle accept-to-accept
    for (int i = 0; i < 15; i++) begin
      chk("tbl_ready_idle", instr_ready, 1);
      opcode = tbl[i].op;
      multiDiv = tbl[i].md;
      mem_ack = 1'b1;
      instr_valid = 1'b1;
      sb.push_back('{tbl[i].ctl, tbl[i].ill});
      step();
      instr_valid = 1'b0;
      w = 0;
      while (!ctrl_valid && w < 4) begin
        step();
        w++;
      end
      chk("tbl_issue_seen", ctrl_valid, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tbl_ctl", ctl_now(), e.ctl);
        chk("tbl_illegal", illegal_op, e.ill);
      end
      chk("tbl_ready_issue", instr_ready, 0);
      step();
      mem_ack = 1'b0;
      chk("tbl_ready_next", instr_ready, 1);
      chk("tbl_ctl_idle", ctl_now(), 0);
      chk("tbl_illegal_once", illegal_op, 0);
    end
    chk("sb_empty", sb.size(), 0);

    // Mult/div: one ISSUE cycle then four MD_WAIT cycles, write-back only in the last
    opcode = 4'b1111;
    multiDiv = 1'b1;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    multiDiv = 1'b0;
    chk("md_issue_valid", ctrl_valid, 1);
    chk("md_issue_rw", regWrite, 0);
    chk("md_issue_ready", instr_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("md_wait_valid", ctrl_valid, 0);
      chk("md_wait_ready", instr_ready, 0);
      chk("md_wait_busy", busy, 1);
      chk("md_wait_rw", regWrite, (i == 3) ? 2'b11 : 2'b00);
    end
    step();
    chk("md_done_ready", instr_ready, 1);
    chk("md_done_rw", regWrite, 0);

    // LW with three cycles of wait, ack on the fourth MEM_WAIT cycle
    opcode = 4'b1100;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("lw_issue_valid", ctrl_valid, 1);
    chk("lw_issue_mr", memRead, 1);
    chk("lw_issue_rw", regWrite, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack = (i == 3);
      #1;
      chk("lw_wait_mr", memRead, 1);
      chk("lw_wait_valid", ctrl_valid, 0);
      chk("lw_wait_ready", instr_ready, 0);
      chk("lw_wait_rw", regWrite, (i == 3) ? 2'b10 : 2'b00);
    end
    step();
    mem_ack = 1'b0;
    chk("lw_done_ready", instr_ready, 1);
    chk("lw_done_mr", memRead, 0);

    // HALT with instructions still streaming in
    opcode = 4'b0000;
    instr_valid = 1'b1;
    step();
    opcode = 4'b0001;
    chk("halt_issue_valid", ctrl_valid, 1);
    chk("halt_issue_ctl", ctl_now(), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_sticky", halted, 1);
      chk("halt_busy", busy, 1);
      chk("halt_ready", instr_ready, 0);
      chk("halt_valid", ctrl_valid, 0);
      chk("halt_ctl", ctl_now(), 0);
    end
    rst = 1'b1;
    step();
    instr_valid = 1'b0;
    rst = 1'b0;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_ready", instr_ready, 1);
    chk("halt_rst_busy", busy, 0);

    // Reset while MD_WAIT counter is at 2 aborts without write-back
    opcode = 4'b1111;
    multiDiv = 1'b1;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    multiDiv = 1'b0;
    step();
    step();
    chk("abort_pre_rw", regWrite, 0);
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ctl", ctl_now(), 0);
    chk("abort_valid", ctrl_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", instr_ready, 1);
    saw_md_wb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (regWrite == 2'b11) saw_md_wb = 1'b1;
    end
    chk("abort_no_md_wb", saw_md_wb, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
